decode_regfile: RTL and testbench



---
 rtl/decode_regfile.sv | 63 ++++++
 tb/tb_decode_regfile.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/decode_regfile.sv
// decode_regfile: decode-stage register file with two combinational read ports, one write port
// and a write-pending scoreboard that raises stall while a source operand is still outstanding.
module decode_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    rs,
    input  logic [ADDR_W-1:0]    rt,
    input  logic [ADDR_W-1:0]    rd,
    input  logic                 r_write,
    input  logic [DATA_W-1:0]    w_data,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_rd,
    output logic [DATA_W-1:0]    dataA,
    output logic [DATA_W-1:0]    dataB,
    output logic                 stall,
    output logic [2**ADDR_W-1:0] busy_vec
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              byp_a, byp_b;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i]  = (r_write && rd == ADDR_W'(i)) ? w_data : mem_q[i];
            // set beats clear: a newer producer issued in the write-back cycle is still outstanding
            busy_d[i] = (issue_valid && issue_rd == ADDR_W'(i)) ||
                        (busy_q[i] && !(r_write && rd == ADDR_W'(i)));
        end
        if (ZERO_REG) begin
            mem_d[0]  = '0;
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            busy_q <= busy_d;
            mem_q  <= mem_d;
        end
    end

    assign byp_a = BYPASS && r_write && rd == rs;
    assign byp_b = BYPASS && r_write && rd == rt;

    always_comb begin
        dataA = (ZERO_REG && rs == '0) ? '0 : byp_a ? w_data : mem_q[rs];
        dataB = (ZERO_REG && rt == '0) ? '0 : byp_b ? w_data : mem_q[rt];
        stall = (busy_q[rs] && !byp_a) || (busy_q[rt] && !byp_b);
    end

    assign busy_vec = busy_q;
endmodule

// File: tb/tb_decode_regfile.sv
// tb_decode_regfile: drives a bypassing instance and a non-bypassing zero-register instance in
// lockstep, comparing both against an array-based reference model.
module tb_decode_regfile;
    logic        clk = 1'b0;
    logic        rst, rw, iv;
    logic [3:0]  rs, rt, rd, ird;
    logic [31:0] wd;
    logic [31:0] da [2];
    logic [31:0] db [2];
    logic        st [2];
    logic [15:0] bv [2];
    logic [31:0] mem_m [2][16];
    logic [15:0] busy_m [2];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_regfile #(.DATA_W(32), .ADDR_W(4), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_byp (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .r_write(rw), .w_data(wd),
        .issue_valid(iv), .issue_rd(ird), .dataA(da[0]), .dataB(db[0]), .stall(st[0]),
        .busy_vec(bv[0]));

    decode_regfile #(.DATA_W(32), .ADDR_W(4), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_zr (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .r_write(rw), .w_data(wd),
        .issue_valid(iv), .issue_rd(ird), .dataA(da[1]), .dataB(db[1]), .stall(st[1]),
        .busy_vec(bv[1]));

    function automatic bit byp(int k); return k == 0; endfunction
    function automatic bit zr(int k);  return k == 1; endfunction

    function automatic logic [31:0] exp_data(int k, logic [3:0] a);
        if (zr(k) && a == 4'd0) return 32'd0;
        if (byp(k) && rw && rd == a) return wd;
        return mem_m[k][a];
    endfunction

    function automatic logic pend(int k, logic [3:0] a);
        return busy_m[k][a] && !(byp(k) && rw && rd == a) && !(zr(k) && a == 4'd0);
    endfunction

    function automatic logic exp_stall(int k);
        return pend(k, rs) || pend(k, rt);
    endfunction

    task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b,
                         input logic w, input logic [3:0] d, input logic [31:0] data,
                         input logic i, input logic [3:0] ir);
        rst = r; rs = a; rt = b; rw = w; rd = d; wd = data; iv = i; ird = ir;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int j = 0; j < 16; j++) mem_m[k][j] = 32'd0;
                busy_m[k] = 16'd0;
            end else begin
                if (rw && !(zr(k) && rd == 4'd0)) mem_m[k][rd] = wd;
                if (rw) busy_m[k][rd] = 1'b0;
                if (iv) busy_m[k][ird] = 1'b1;
                if (zr(k)) busy_m[k][0] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 1, 3, 32'h33, 1, 3); tick();
        drive(0, 0, 0, 1, 9, 32'h99, 1, 9); tick();
        drive(1, 0, 0, 0, 0, 0, 1, 5); tick();
        drive(0, 3, 9, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            checks += 4;
            if (da[k] !== 32'd0) begin errors++; $display("FAIL reset_dataA cfg%0d got %h exp 0", k, da[k]); end
            if (db[k] !== 32'd0) begin errors++; $display("FAIL reset_dataB cfg%0d got %h exp 0", k, db[k]); end
            if (bv[k] !== 16'd0) begin errors++; $display("FAIL reset_busy cfg%0d got %h exp 0", k, bv[k]); end
            if (st[k] !== 1'b0)  begin errors++; $display("FAIL reset_stall cfg%0d got %b exp 0", k, st[k]); end
        end
    endtask

    task automatic test_write_read();
        drive(0, 5, 0, 1, 5, 32'hA5, 0, 0);
        checks += 2;
        if (da[0] !== 32'hA5) begin errors++; $display("FAIL bypass_read got %h exp 000000a5", da[0]); end
        if (da[1] !== 32'd0) begin errors++; $display("FAIL nobypass_read got %h exp 0", da[1]); end
        tick();
        drive(0, 5, 5, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            checks += 2;
            if (da[k] !== 32'hA5) begin errors++; $display("FAIL write_read_A cfg%0d got %h exp 000000a5", k, da[k]); end
            if (db[k] !== 32'hA5) begin errors++; $display("FAIL write_read_B cfg%0d got %h exp 000000a5", k, db[k]); end
        end
    endtask

    task automatic test_hazard();
        drive(0, 7, 0, 0, 0, 0, 1, 7); tick();
        drive(0, 7, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            checks += 2;
            if (st[k] !== 1'b1)    begin errors++; $display("FAIL hazard_stall cfg%0d got %b exp 1", k, st[k]); end
            if (bv[k][7] !== 1'b1) begin errors++; $display("FAIL hazard_busy cfg%0d got %b exp 1", k, bv[k][7]); end
        end
        drive(0, 7, 0, 1, 7, 32'h1234, 0, 0);
        checks += 3;
        if (st[0] !== 1'b0) begin errors++; $display("FAIL wb_stall_bypass got %b exp 0", st[0]); end
        if (da[0] !== 32'h1234) begin errors++; $display("FAIL wb_data_bypass got %h exp 00001234", da[0]); end
        if (st[1] !== 1'b1) begin errors++; $display("FAIL wb_stall_nobypass got %b exp 1", st[1]); end
        tick();
        drive(0, 7, 0, 0, 0, 0, 0, 0);
        checks += 2;
        if (st[1] !== 1'b0) begin errors++; $display("FAIL release_stall got %b exp 0", st[1]); end
        if (da[1] !== 32'h1234) begin errors++; $display("FAIL release_data got %h exp 00001234", da[1]); end
    endtask

    task automatic test_set_clear();
        drive(0, 0, 0, 1, 4, 32'hCAFE, 1, 4); tick();
        drive(0, 4, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            checks += 3;
            if (bv[k][4] !== 1'b1)   begin errors++; $display("FAIL setclr_busy cfg%0d got %b exp 1", k, bv[k][4]); end
            if (da[k] !== 32'hCAFE)  begin errors++; $display("FAIL setclr_data cfg%0d got %h exp 0000cafe", k, da[k]); end
            if (st[k] !== 1'b1)      begin errors++; $display("FAIL setclr_stall cfg%0d got %b exp 1", k, st[k]); end
        end
    endtask

    task automatic test_zero_reg();
        drive(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks += 6;
        if (da[1] !== 32'd0) begin errors++; $display("FAIL zero_data got %h exp 0", da[1]); end
        if (bv[1][0] !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", bv[1][0]); end
        if (st[1] !== 1'b0) begin errors++; $display("FAIL zero_stall got %b exp 0", st[1]); end
        if (da[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL r0_data got %h exp ffffffff", da[0]); end
        if (bv[0][0] !== 1'b1) begin errors++; $display("FAIL r0_busy got %b exp 1", bv[0][0]); end
        if (st[0] !== 1'b1) begin errors++; $display("FAIL r0_stall got %b exp 1", st[0]); end
    endtask

    task automatic test_reset_busy();
        drive(0, 0, 0, 0, 0, 0, 1, 2); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 3); tick();
        drive(1, 0, 0, 1, 2, 32'hDEAD, 1, 5); tick();
        drive(0, 2, 3, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            checks += 3;
            if (bv[k] !== 16'd0) begin errors++; $display("FAIL rstbusy_vec cfg%0d got %h exp 0", k, bv[k]); end
            if (da[k] !== 32'd0) begin errors++; $display("FAIL rstbusy_mem2 cfg%0d got %h exp 0", k, da[k]); end
            if (st[k] !== 1'b0)  begin errors++; $display("FAIL rstbusy_stall cfg%0d got %b exp 0", k, st[k]); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 49) == 0, 4'($urandom), 4'($urandom), $urandom_range(0, 1) == 1,
                  4'($urandom), $urandom, $urandom_range(0, 2) == 0, 4'($urandom));
            for (int k = 0; k < 2; k++) begin
                checks += 4;
                if (da[k] !== exp_data(k, rs)) begin errors++; $display("FAIL rand_dataA cfg%0d n%0d got %h exp %h", k, n, da[k], exp_data(k, rs)); end
                if (db[k] !== exp_data(k, rt)) begin errors++; $display("FAIL rand_dataB cfg%0d n%0d got %h exp %h", k, n, db[k], exp_data(k, rt)); end
                if (st[k] !== exp_stall(k)) begin errors++; $display("FAIL rand_stall cfg%0d n%0d got %b exp %b", k, n, st[k], exp_stall(k)); end
                if (bv[k] !== busy_m[k]) begin errors++; $display("FAIL rand_busy cfg%0d n%0d got %h exp %h", k, n, bv[k], busy_m[k]); end
            end
            tick();
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        test_reset();
        test_write_read();
        test_hazard();
        test_set_clear();
        test_zero_reg();
        test_reset_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
